// File: rtl/bkm_control_step_driver.sv
// Stimulus sequencer for a BKM step unit: issues LFSR-derived operand
// vectors, tracks the DUT pipeline with a valid shift register, and
// counts checker verdicts. The FSM state is exposed on dbg_state.
//
// Handshake: a vector is presented on tb_* for exactly the cycle(s)
// dut_valid=1, and it counts as consumed on each cycle where
// dut_valid=1 and enable=1. chk_enable marks the cycle the downstream
// checker compares that vector. The err_*/war_* flags are sampled one
// enabled cycle after that.
module bkm_control_step_driver #(
  parameter int W     = 64,
  parameter int LOG2N = 6,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_vec,
  input  logic             err_u,
  input  logic             err_v,
  input  logic             war_u,
  input  logic             war_v,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_u_n,
  output logic [1:0]       tb_d_v_n,
  output logic [W-1:0]     tb_u_n,
  output logic [W-1:0]     tb_v_n,
  output logic             dut_valid,
  output logic             chk_enable,
  output logic [15:0]      vec_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      war_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] B_XOR     = 32'hA5A5A5A5;

  // Right-shifting Galois LFSR, one step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    lfsr_step = (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Digit code 2'b10 is not a legal digit; fold it onto zero.
  function automatic logic [1:0] digit(input logic [1:0] x);
    digit = (x == 2'b10) ? 2'b00 : x;
  endfunction

  // {x, ~x} repeated across the operand, keeping the W LSBs.
  function automatic logic [W-1:0] expand(input logic [31:0] x);
    logic [63:0] pat;
    pat = {x, ~x};
    for (int i = 0; i < W; i++) expand[i] = pat[i % 64];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [15:0]        num_vec_q, num_vec_d;
  logic [15:0]        vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d, war_cnt_q, war_cnt_d;
  logic [3:0]         drain_cnt_q, drain_cnt_d;
  logic [LAT-1:0]     chk_sr_q, chk_sr_d;
  logic               strobe_q, strobe_d;
  logic               dut_valid_q, dut_valid_d;
  logic               tb_mode_q, tb_mode_d;
  logic [1:0]         tb_format_q, tb_format_d, tb_d_u_n_q, tb_d_u_n_d, tb_d_v_n_q, tb_d_v_n_d;
  logic [LOG2N-1:0]   tb_n_q, tb_n_d;
  logic [W-1:0]       tb_u_n_q, tb_u_n_d, tb_v_n_q, tb_v_n_d;

  logic               issue;
  logic [31:0]        src_a, src_b, seed_eff;
  logic [15:0]        cnt_base;
  logic [LAT:0]       sr_shift;

  // Next-state, vector issue, pipeline tracking and verdict counting.
  always_comb begin
    state_d     = state_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    num_vec_d   = num_vec_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    war_cnt_d   = war_cnt_q;
    drain_cnt_d = drain_cnt_q;
    chk_sr_d    = chk_sr_q;
    strobe_d    = strobe_q;
    dut_valid_d = dut_valid_q;
    tb_mode_d   = tb_mode_q;
    tb_format_d = tb_format_q;
    tb_n_d      = tb_n_q;
    tb_d_u_n_d  = tb_d_u_n_q;
    tb_d_v_n_d  = tb_d_v_n_q;
    tb_u_n_d    = tb_u_n_q;
    tb_v_n_d    = tb_v_n_q;
    issue       = 1'b0;
    src_a       = lfsr_a_q;
    src_b       = lfsr_b_q;
    cnt_base    = vec_cnt_q;
    seed_eff    = (seed == 32'h0) ? 32'h1 : seed;
    sr_shift    = {chk_sr_q, dut_valid_q};

    if (srst) begin
      state_d     = S_IDLE;
      lfsr_a_d    = 32'h1;
      lfsr_b_d    = 32'h1;
      num_vec_d   = '0;
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      war_cnt_d   = '0;
      drain_cnt_d = '0;
      chk_sr_d    = '0;
      strobe_d    = 1'b0;
      dut_valid_d = 1'b0;
      tb_mode_d   = 1'b0;
      tb_format_d = '0;
      tb_n_d      = '0;
      tb_d_u_n_d  = '0;
      tb_d_v_n_d  = '0;
      tb_u_n_d    = '0;
      tb_v_n_d    = '0;
    end else if (enable) begin
      chk_sr_d = sr_shift[LAT-1:0];
      strobe_d = chk_sr_q[LAT-1];
      // At most one count per verdict; errors take precedence.
      if (strobe_q) begin
        if (err_u | err_v)      err_cnt_d = sat_inc(err_cnt_q);
        else if (war_u | war_v) war_cnt_d = sat_inc(war_cnt_q);
      end
      dut_valid_d = 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_vec_d = num_vec;
            vec_cnt_d = '0;
            err_cnt_d = '0;
            war_cnt_d = '0;
            if (num_vec != 16'd0) begin
              // First vector goes out with the start edge.
              issue    = 1'b1;
              src_a    = seed_eff;
              src_b    = seed_eff ^ B_XOR;
              cnt_base = '0;
              state_d  = S_RUN;
            end else begin
              lfsr_a_d = seed_eff;
              lfsr_b_d = seed_eff ^ B_XOR;
              state_d  = S_DONE;
            end
          end
        end
        S_RUN: begin
          if (vec_cnt_q != num_vec_q) begin
            issue = 1'b1;
          end else begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == 4'(LAT)) state_d = S_DONE;
          else                        drain_cnt_d = drain_cnt_q + 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
      if (issue) begin
        dut_valid_d = 1'b1;
        tb_mode_d   = src_a[0];
        tb_format_d = src_a[2:1];
        tb_d_u_n_d  = digit(src_a[4:3]);
        tb_d_v_n_d  = digit(src_b[4:3]);
        tb_u_n_d    = expand(src_a);
        tb_v_n_d    = expand(src_b);
        tb_n_d      = cnt_base[LOG2N-1:0];
        vec_cnt_d   = sat_inc(cnt_base);
        lfsr_a_d    = lfsr_step(src_a);
        lfsr_b_d    = lfsr_step(src_b);
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      lfsr_a_q    <= 32'h1;
      lfsr_b_q    <= 32'h1;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      war_cnt_q   <= '0;
      drain_cnt_q <= '0;
      chk_sr_q    <= '0;
      strobe_q    <= 1'b0;
      dut_valid_q <= 1'b0;
      tb_mode_q   <= 1'b0;
      tb_format_q <= '0;
      tb_n_q      <= '0;
      tb_d_u_n_q  <= '0;
      tb_d_v_n_q  <= '0;
      tb_u_n_q    <= '0;
      tb_v_n_q    <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      num_vec_q   <= num_vec_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      war_cnt_q   <= war_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      chk_sr_q    <= chk_sr_d;
      strobe_q    <= strobe_d;
      dut_valid_q <= dut_valid_d;
      tb_mode_q   <= tb_mode_d;
      tb_format_q <= tb_format_d;
      tb_n_q      <= tb_n_d;
      tb_d_u_n_q  <= tb_d_u_n_d;
      tb_d_v_n_q  <= tb_d_v_n_d;
      tb_u_n_q    <= tb_u_n_d;
      tb_v_n_q    <= tb_v_n_d;
    end
  end

  assign tb_mode    = tb_mode_q;
  assign tb_format  = tb_format_q;
  assign tb_n       = tb_n_q;
  assign tb_d_u_n   = tb_d_u_n_q;
  assign tb_d_v_n   = tb_d_v_n_q;
  assign tb_u_n     = tb_u_n_q;
  assign tb_v_n     = tb_v_n_q;
  assign dut_valid  = dut_valid_q;
  assign chk_enable = chk_sr_q[LAT-1];
  assign vec_cnt    = vec_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign war_cnt    = war_cnt_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bkm_control_step_driver.sv
// Directed bench for bkm_control_step_driver (W=64, LOG2N=6, LAT=1).
module tb_bkm_control_step_driver;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        srst = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [15:0] num_vec = '0;
  logic        err_u = 1'b0, err_v = 1'b0, war_u = 1'b0, war_v = 1'b0;
  logic        tb_mode;
  logic [1:0]  tb_format, tb_d_u_n, tb_d_v_n;
  logic [5:0]  tb_n;
  logic [63:0] tb_u_n, tb_v_n;
  logic        dut_valid, chk_enable, busy, done;
  logic [15:0] vec_cnt, err_cnt, war_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] vtab [0:127];  // per-vector {err_u, err_v, war_u, war_v}

  bkm_control_step_driver #(.W(64), .LOG2N(6), .LAT(1)) dut (
    .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable), .start(start),
    .seed(seed), .num_vec(num_vec), .err_u(err_u), .err_v(err_v),
    .war_u(war_u), .war_v(war_v), .tb_mode(tb_mode), .tb_format(tb_format),
    .tb_n(tb_n), .tb_d_u_n(tb_d_u_n), .tb_d_v_n(tb_d_v_n), .tb_u_n(tb_u_n),
    .tb_v_n(tb_v_n), .dut_valid(dut_valid), .chk_enable(chk_enable),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .war_cnt(war_cnt), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model pieces
  function automatic logic [31:0] m_step(input logic [31:0] x);
    logic [31:0] r;
    r = {1'b0, x[31:1]};
    if (x[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [1:0] m_digit(input logic [1:0] x);
    return (x == 2'b10) ? 2'b00 : x;
  endfunction

  task automatic clear_vtab();
    for (int i = 0; i < 128; i++) vtab[i] = 4'h0;
  endtask

  task automatic do_start(input logic [31:0] sd, input int nv);
    seed = sd;
    num_vec = 16'(nv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one start..done sequence, checking every vector against the model.
  task automatic run_vec(input string tag, input logic [31:0] sd, input int nv,
                         input int fr_at, input int fr_len, input int poke_at,
                         input int exp_err, input int exp_war);
    logic [31:0] a, b;
    int k, nchk, last_chk, first_done, idx;
    bit finished, bad_digit;
    a = (sd == 0) ? 32'h1 : sd;
    b = a ^ 32'hA5A5A5A5;
    k = 0; nchk = 0; last_chk = -100; first_done = -1;
    finished = 0; bad_digit = 0;
    do_start(sd, nv);
    for (int t = 0; t < nv + 60 && !finished; t++) begin
      enable = !(t >= fr_at && t < fr_at + fr_len);
      idx = t - 2;
      {err_u, err_v, war_u, war_v} = (idx >= 0 && idx < nv) ? vtab[idx] : 4'h0;
      start = (t == poke_at);
      num_vec = (t == poke_at) ? 16'd1 : 16'(nv);
      if (enable) begin
        if (dut_valid) begin
          check({tag, "_tb_n"}, 64'(tb_n), 64'(k % 64));
          check({tag, "_vec_cnt"}, 64'(vec_cnt), 64'(k + 1));
          check({tag, "_u"}, tb_u_n, {a, ~a});
          check({tag, "_v"}, tb_v_n, {b, ~b});
          check({tag, "_mode_fmt"}, 64'({tb_mode, tb_format}), 64'({a[0], a[2:1]}));
          check({tag, "_digits"}, 64'({tb_d_u_n, tb_d_v_n}), 64'({m_digit(a[4:3]), m_digit(b[4:3])}));
          if (tb_d_u_n == 2'b10 || tb_d_v_n == 2'b10) bad_digit = 1;
          a = m_step(a);
          b = m_step(b);
          k++;
        end
        if (chk_enable) begin
          nchk++;
          last_chk = t;
        end
        if (done) begin
          first_done = t;
          finished = 1;
        end
      end else if (dut_valid) begin
        check({tag, "_frz_tb_n"}, 64'(tb_n), 64'(k % 64));
        check({tag, "_frz_vec_cnt"}, 64'(vec_cnt), 64'(k + 1));
      end
      tick();
    end
    enable = 1'b1;
    start = 1'b0;
    {err_u, err_v, war_u, war_v} = 4'h0;
    check({tag, "_done_seen"}, 64'(finished), 64'd1);
    check({tag, "_pulses"}, 64'(k), 64'(nv));
    check({tag, "_chk_pulses"}, 64'(nchk), 64'(nv));
    check({tag, "_done_delay"}, 64'(first_done - last_chk), 64'd2);
    check({tag, "_vec_cnt_end"}, 64'(vec_cnt), 64'(nv));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_war_cnt"}, 64'(war_cnt), 64'(exp_war));
    check({tag, "_no_10_digit"}, 64'(bad_digit), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [63:0] first_u;
    clear_vtab();

    // Reset state
    tick(); tick();
    check("rst_dut_valid", 64'(dut_valid), 64'd0);
    check("rst_chk", 64'(chk_enable), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_cnts", {16'h0, vec_cnt, err_cnt, war_cnt}, 64'd0);
    check("rst_tb_u", tb_u_n, 64'd0);
    arst_n = 1'b1;
    tick();

    // Basic run: seed 1, three vectors
    run_vec("basic", 32'h1, 3, -1, 0, -1, 0, 0);

    // Verdict counting: err_u on 2nd, war_v on 3rd, err_v+war_u on 4th
    vtab[1] = 4'b1000;
    vtab[2] = 4'b0001;
    vtab[3] = 4'b0110;
    run_vec("verdict", 32'h1234_5678, 4, -1, 0, -1, 2, 1);
    clear_vtab();

    // Zero-length run clears counters and goes straight to DONE
    do_start(32'h5, 0);
    check("nv0_done", 64'(done), 64'd1);
    check("nv0_valid", 64'(dut_valid), 64'd0);
    check("nv0_cnts", {16'h0, vec_cnt, err_cnt, war_cnt}, 64'd0);
    tick();
    check("nv0_valid2", 64'(dut_valid), 64'd0);

    // Freeze mid-run, plus a start poke while busy that must be ignored
    run_vec("freeze", 32'hCAFE_0001, 8, 3, 5, 1, 0, 0);

    // Seed 0 maps onto seed 1
    run_vec("seed0", 32'h0, 2, -1, 0, -1, 0, 0);

    // Long run: tb_n wraps 63 -> 0
    run_vec("wrap", 32'hDEAD_BEEF, 70, -1, 0, -1, 0, 0);

    // Async reset during DRAIN
    do_start(32'h0BAD_F00D, 6);
    first_u = tb_u_n;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (dbg_state == 2'd2) seen = 1;
      else tick();
    end
    check("drain_reached", 64'(seen), 64'd1);
    arst_n = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'd0);
    check("arst_outs", {16'h0, vec_cnt, 14'h0, busy, done, chk_enable, dut_valid, 12'h0}, 64'd0);
    check("arst_tb_u", tb_u_n, 64'd0);
    tick();
    arst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dut_valid || chk_enable) seen = 1;
      tick();
    end
    check("arst_no_pulse", 64'(seen), 64'd0);
    check("arst_first_u", first_u, {32'h0BAD_F00D, ~32'h0BAD_F00D});
    run_vec("rerun", 32'h0BAD_F00D, 6, -1, 0, -1, 0, 0);

    // Synchronous reset mid-RUN
    do_start(32'h7777_1111, 10);
    tick(); tick();
    srst = 1'b1;
    check("srst_async_free", 64'(dut_valid), 64'd1);
    tick();
    srst = 1'b0;
    check("srst_state", 64'(dbg_state), 64'd0);
    check("srst_outs", {16'h0, vec_cnt, 16'h0, 12'h0, busy, done, chk_enable, dut_valid}, 64'd0);
    check("srst_tb_u", tb_u_n, 64'd0);
    tick(); tick();
    check("srst_no_pulse", 64'({dut_valid, chk_enable}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bkm_control_step_driver.md
BKM_CONTROL_STEP_DRIVER -- requirements
Module: bkm_control_step_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; reset port SHALL be named arst_n, clock port clk.
REQ-002 Parameter W, default 64, data word width of u/v operands.
REQ-003 Parameter LOG2N, default 6, width of iteration index n.
REQ-004 Parameter LAT, default 1, range 1..8, DUT latency in clk cycles from vector applied to result valid.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 srst  in  1  synchronous active-high reset, same effect as arst_n.
REQ-008 enable  in  1  global advance; when 0 all state SHALL hold.
REQ-009 start  in  1  single-cycle run request, honoured in IDLE or DONE only.
REQ-010 seed  in  32  LFSR seed, sampled on accepted start.
REQ-011 num_vec  in  16  vectors to issue, sampled on accepted start.
REQ-012 err_u, err_v, war_u, war_v  in  1 each  checker verdict flags, valid one cycle after chk_enable.
REQ-013 tb_mode  out  1; tb_format  out  2; tb_n  out  LOG2N; tb_d_u_n, tb_d_v_n  out  2 each; tb_u_n, tb_v_n  out  W: stimulus to DUT and reference model.
REQ-014 dut_valid  out  1  stimulus on tb_* valid this cycle.
REQ-015 chk_enable  out  1  checker enable, dut_valid delayed LAT enabled cycles.
REQ-016 vec_cnt  out  16  vectors issued; err_cnt, war_cnt  out  16 each  saturating verdict counters.
REQ-017 busy  out  1  state is RUN or DRAIN; done  out  1  state is DONE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE/DONE + start: num_vec!=0 -> RUN, clear vec_cnt/err_cnt/war_cnt, load LFSRs; num_vec==0 -> DONE with counters cleared.
REQ-020 start while busy SHALL be ignored.
REQ-021 RUN: one vector per enabled cycle, dut_valid=1, vec_cnt+1; after vector num_vec issued -> DRAIN.
REQ-022 DRAIN SHALL last LAT+1 enabled cycles (pipeline flush plus verdict cycle), then -> DONE; dut_valid=0.
REQ-023 DONE holds done=1 until accepted start or reset.
REQ-024 Two 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003): A seeded with seed, B with seed^32'hA5A5A5A5; seed value 0 SHALL be replaced by 32'h00000001 (B uses 32'h00000001^32'hA5A5A5A5); each advances once per issued vector.
REQ-025 tb_u_n = {A, ~A} replicated, truncated to W LSBs; tb_v_n same from B.
REQ-026 tb_mode=A[0]; tb_format=A[2:1]; tb_d_u_n=A[4:3]; tb_d_v_n=B[4:3]; digit code 2'b10 SHALL be remapped to 2'b00 (legal codes 00=0, 01=+1, 11=-1).
REQ-027 tb_n = vec_cnt[LOG2N-1:0] before increment (sweeps 0..2^LOG2N-1, wraps).
REQ-028 tb_* SHALL be registered outputs, stable while dut_valid=0.
REQ-029 chk_enable SHALL be produced by an LAT-deep shift register of dut_valid advancing only when enable=1.
REQ-030 Verdict strobe = chk_enable delayed 1 enabled cycle; on strobe: err_cnt+1 if err_u|err_v; else war_cnt+1 if war_u|war_v; one count per vector maximum.
REQ-031 err_cnt, war_cnt, vec_cnt SHALL saturate at 16'hFFFF.
REQ-032 enable=0 mid-run SHALL freeze FSM, LFSRs, counters, shift register; outputs hold.

Reset
REQ-033 On arst_n=0 (immediate) or srst=1 (next edge): state IDLE, all outputs 0, LFSRs 32'h00000001, shift register cleared.
REQ-034 Reset mid-RUN/DRAIN SHALL abort the run with no further dut_valid or chk_enable pulses.

Verification
REQ-035 seed=1, num_vec=3, LAT=1, enable=1: dut_valid high 3 cycles, chk_enable high 3 cycles one later, done 2 cycles after last chk_enable, vec_cnt=3, tb_n=0,1,2.
REQ-036 num_vec=0 + start: done=1 next cycle, dut_valid never asserted, counters 0.
REQ-037 num_vec=4, err_u=1 on 2nd strobe, war_v=1 on 3rd, both err_v and war_u on 4th: err_cnt=2, war_cnt=1.
REQ-038 enable toggled 0 for 5 cycles mid-RUN: tb_* and vec_cnt unchanged, total 8 dut_valid pulses for num_vec=8, LFSR sequence identical to uninterrupted run.
REQ-039 arst_n pulsed low during DRAIN: outputs 0 immediately, IDLE; subsequent start with same seed reproduces identical tb_u_n sequence.
REQ-040 num_vec=70, LOG2N=6: tb_n wraps 63->0 at vector 64; no tb_d_*_n equals 2'b10 across run.
